// File: rtl/beat_control_alu.sv
// beat_control_alu: SAP-style execution core combining the six-state timing ring,
// the opcode decoder that drives every W-bus strobe, and the accumulator/adder datapath.
module beat_control_alu (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] operate_code,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       t0,
    output logic       t1,
    output logic       t2,
    output logic       t3,
    output logic       t4,
    output logic       t5,
    output logic       lp,
    output logic       ep,
    output logic       lm,
    output logic       epr,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       n,
    output logic       ev,
    output logic       lb,
    output logic       lo,
    output logic       cout,
    output logic [7:0] a_reg
);
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [5:0] {
        ST_T0 = 6'b000001,
        ST_T1 = 6'b000010,
        ST_T2 = 6'b000100,
        ST_T3 = 6'b001000,
        ST_T4 = 6'b010000,
        ST_T5 = 6'b100000
    } ring_e;

    ring_e      ring_q, ring_d;
    logic       halt_q, halt_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] addend_s;
    logic [8:0] sum_s;
    logic [5:0] ring_vec_s;

    // State registers: ring, halt flag, A and B.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ring_q <= ST_T0;
            halt_q <= 1'b0;
            a_q    <= 8'h00;
            b_q    <= 8'h00;
        end else begin
            ring_q <= ring_d;
            halt_q <= halt_d;
            a_q    <= a_d;
            b_q    <= b_d;
        end
    end

    // Ring advance and strobe decode; a set halt flag freezes the ring and silences everything.
    always_comb begin
        ring_d = ring_q;
        halt_d = halt_q;
        lp = 1'b0; ep = 1'b0; lm = 1'b0; epr = 1'b0; li = 1'b0; ei = 1'b0;
        la = 1'b0; ea = 1'b0; n  = 1'b0; ev  = 1'b0; lb = 1'b0; lo = 1'b0;
        if (!halt_q) begin
            case (ring_q)
                ST_T0: begin ep = 1'b1; lm = 1'b1; ring_d = ST_T1; end
                ST_T1: begin epr = 1'b1; li = 1'b1; ring_d = ST_T2; end
                ST_T2: begin lp = 1'b1; ring_d = ST_T3; end
                ST_T3: begin
                    ring_d = ST_T4;
                    case (operate_code)
                        OP_LDA, OP_ADD, OP_SUB: begin ei = 1'b1; lm = 1'b1; end
                        OP_OUT: begin ea = 1'b1; lo = 1'b1; end
                        OP_HLT: begin halt_d = 1'b1; ring_d = ST_T3; end
                        default: ring_d = ST_T4;
                    endcase
                end
                ST_T4: begin
                    ring_d = ST_T5;
                    case (operate_code)
                        OP_LDA: begin epr = 1'b1; la = 1'b1; end
                        OP_ADD, OP_SUB: begin epr = 1'b1; lb = 1'b1; end
                        default: ring_d = ST_T5;
                    endcase
                end
                ST_T5: begin
                    ring_d = ST_T0;
                    case (operate_code)
                        OP_ADD, OP_SUB: begin ev = 1'b1; la = 1'b1; end
                        default: ring_d = ST_T0;
                    endcase
                end
                default: ring_d = ST_T0;
            endcase
            if ((ring_q == ST_T3 || ring_q == ST_T4 || ring_q == ST_T5) &&
                (operate_code == OP_SUB)) begin
                n = 1'b1;
            end else begin
                n = 1'b0;
            end
        end else begin
            ring_d = ring_q;
        end
    end

    // Register load enables.
    always_comb begin
        a_d = la ? bus_in : a_q;
        b_d = lb ? bus_in : b_q;
    end

    // Subtraction as two's complement: invert B and inject n as carry-in.
    always_comb begin
        addend_s = b_q ^ {8{n}};
        sum_s    = {1'b0, a_q} + {1'b0, addend_s} + {8'h00, n};
    end

    // W-bus driver; A onto the bus wins over the adder result.
    always_comb begin
        if (ea) begin
            bus_out = a_q;
        end else if (ev) begin
            bus_out = sum_s[7:0];
        end else begin
            bus_out = 8'h00;
        end
        bus_oe = ea | ev;
    end

    assign ring_vec_s = ring_q;
    assign t0    = ring_vec_s[0];
    assign t1    = ring_vec_s[1];
    assign t2    = ring_vec_s[2];
    assign t3    = ring_vec_s[3];
    assign t4    = ring_vec_s[4];
    assign t5    = ring_vec_s[5];
    assign cout  = sum_s[8];
    assign a_reg = a_q;
endmodule

// File: tb/tb_beat_control_alu.sv
// Self-checking bench for beat_control_alu: instruction-level reference model,
// bus scoreboard drained by an independent monitor, plus per-state strobe checks.
module tb_beat_control_alu;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] op_r;
    logic [7:0] data_r;
    logic       loop_r;
    logic [7:0] bus_in, bus_out, a_reg;
    logic       bus_oe, cout;
    logic       t0, t1, t2, t3, t4, t5;
    logic       lp, ep, lm, epr, li, ei, la, ea, n, ev, lb, lo;
    logic [11:0] strb;
    logic [5:0]  ring;

    localparam logic [11:0] S_LP  = 12'h800, S_EP = 12'h400, S_LM = 12'h200, S_EPR = 12'h100;
    localparam logic [11:0] S_LI  = 12'h080, S_EI = 12'h040, S_LA = 12'h020, S_EA  = 12'h010;
    localparam logic [11:0] S_N   = 12'h008, S_EV = 12'h004, S_LB = 12'h002, S_LO  = 12'h001;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] a_m;

    assign bus_in = loop_r ? bus_out : data_r;
    assign strb   = {lp, ep, lm, epr, li, ei, la, ea, n, ev, lb, lo};
    assign ring   = {t5, t4, t3, t2, t1, t0};

    always #5 clk = ~clk;

    beat_control_alu dut (
        .clk(clk), .reset(reset), .operate_code(op_r), .bus_in(bus_in),
        .bus_out(bus_out), .bus_oe(bus_oe),
        .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5),
        .lp(lp), .ep(ep), .lm(lm), .epr(epr), .li(li), .ei(ei), .la(la), .ea(ea),
        .n(n), .ev(ev), .lb(lb), .lo(lo), .cout(cout), .a_reg(a_reg)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    endtask

    // Strobes an instruction should show in state k, straight from the instruction table.
    function automatic logic [11:0] exp_strobes(input int k, input logic [3:0] op);
        logic [11:0] s;
        s = 12'h000;
        if (k == 0) s = S_EP | S_LM;
        else if (k == 1) s = S_EPR | S_LI;
        else if (k == 2) s = S_LP;
        else if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
            if (k == 3) s = S_EI | S_LM;
            if (k == 4) s = S_EPR | ((op == 4'h0) ? S_LA : S_LB);
            if (k == 5 && op != 4'h0) s = S_EV | S_LA;
            if (op == 4'h2) s = s | S_N;
        end else if (op == 4'hE && k == 3) s = S_EA | S_LO;
        return s;
    endfunction

    // Monitor: drains the scoreboard whenever the block drives the bus.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (bus_oe) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL bus_unexpected: got %h, required no drive", bus_out);
                end else begin
                    check("bus_out", {8'h00, bus_out}, {8'h00, exp_q.pop_front()});
                end
            end else begin
                check("bus_idle", {8'h00, bus_out}, 16'h0000);
            end
        end
    end

    // Runs one instruction from T0; called at a falling edge with the ring in t0.
    task automatic run_instr(input logic [3:0] op, input logic [7:0] data, input int abort_k);
        int         r;
        logic [7:0] res;
        logic       carry;
        r = 0; res = a_m; carry = 1'b0;
        if (op == 4'h1) begin
            r = int'(a_m) + int'(data); res = 8'(r % 256); carry = (r > 255);
        end else if (op == 4'h2) begin
            r = int'(a_m) - int'(data); res = 8'((r + 256) % 256); carry = (r >= 0);
        end
        if ((op == 4'h1 || op == 4'h2) && abort_k < 0) exp_q.push_back(res);
        if (op == 4'hE) exp_q.push_back(a_m);
        for (int k = 0; k < 6; k++) begin
            op_r   = (k < 2) ? 4'($urandom_range(0, 15)) : op;
            data_r = (k == 4) ? data : 8'($urandom);
            loop_r = (k == 5) && (op == 4'h1 || op == 4'h2);
            #1;
            check("ring", {10'h000, ring}, {10'h000, 6'(1 << k)});
            check("strobes", {4'h0, strb}, {4'h0, exp_strobes(k, op)});
            if (k == 5 && (op == 4'h1 || op == 4'h2)) check("cout", {15'h0, cout}, {15'h0, carry});
            if (k == abort_k) begin
                reset = 1'b1;
                #1;
                check("rst_ring", {10'h000, ring}, 16'h0001);
                check("rst_a", {8'h00, a_reg}, 16'h0000);
                check("rst_strobes", {4'h0, strb}, {4'h0, S_EP | S_LM});
                exp_q.delete();
                a_m = 8'h00;
                @(negedge clk);
                reset  = 1'b0;
                loop_r = 1'b0;
                return;
            end
            @(negedge clk);
        end
        loop_r = 1'b0;
        if (op == 4'h0) a_m = data;
        else if (op == 4'h1 || op == 4'h2) a_m = res;
        check("a_reg", {8'h00, a_reg}, {8'h00, a_m});
    endtask

    // HLT: ring parks in t3 with every strobe low until reset.
    task automatic run_halt();
        for (int k = 0; k < 4; k++) begin
            op_r   = (k < 2) ? 4'($urandom_range(0, 15)) : 4'hF;
            data_r = 8'($urandom);
            #1;
            check("halt_ring", {10'h000, ring}, {10'h000, 6'(1 << k)});
            check("halt_strobes", {4'h0, strb}, {4'h0, exp_strobes(k, 4'hF)});
            @(negedge clk);
        end
        repeat (20) begin
            data_r = 8'($urandom);
            #1;
            check("frozen_ring", {10'h000, ring}, 16'h0008);
            check("frozen_strobes", {4'h0, strb}, 16'h0000);
            check("frozen_a", {8'h00, a_reg}, {8'h00, a_m});
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        check("unhalt_ring", {10'h000, ring}, 16'h0001);
        check("unhalt_strobes", {4'h0, strb}, {4'h0, S_EP | S_LM});
        a_m = 8'h00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int         sel;
    logic [3:0] rop;

    initial begin
        reset = 1'b1; op_r = 4'h0; data_r = 8'h00; loop_r = 1'b0; a_m = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ring", {10'h000, ring}, 16'h0001);
        check("reset_strobes", {4'h0, strb}, {4'h0, S_EP | S_LM});
        check("reset_a", {8'h00, a_reg}, 16'h0000);
        check("reset_cout", {15'h0, cout}, 16'h0000);
        check("reset_oe", {15'h0, bus_oe}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        run_instr(4'h5, 8'h00, -1);
        run_instr(4'h5, 8'h00, -1);
        run_instr(4'h0, 8'h27, -1);
        run_instr(4'h1, 8'h19, -1);
        run_instr(4'h0, 8'hFF, -1);
        run_instr(4'h1, 8'h01, -1);
        run_instr(4'h0, 8'h10, -1);
        run_instr(4'h2, 8'h11, -1);
        run_instr(4'h2, 8'h0F, -1);
        run_instr(4'hE, 8'h00, -1);
        run_instr(4'h0, 8'h33, -1);
        run_instr(4'h1, 8'h44, 4);
        run_instr(4'hE, 8'h00, -1);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: rop = 4'h0;
                1: rop = 4'h1;
                2: rop = 4'h2;
                3: rop = 4'hE;
                default: rop = 4'($urandom_range(3, 13));
            endcase
            run_instr(rop, 8'($urandom), -1);
        end

        run_instr(4'hE, 8'h00, -1);
        run_halt();
        run_instr(4'h0, 8'h5A, -1);
        check("sb_empty", 16'(exp_q.size()), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/beat_control_alu.md
# beat_control_alu

Execution core of the 8-bit SAP-style CPU. It combines the six-phase timing ring (`beat`), the opcode-decoding control unit (`control_unit`) and the accumulator/adder datapath (`alu_adder`). It sits on the shared 8-bit W bus alongside the PC, MAR/PROM, IR and output register, and it generates every load and enable strobe for those blocks.

## Interface
- Parameters: none. The data width is fixed at 8 bits.
- `clk` input 1: single system clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `operate_code` input 4: opcode from the IR's upper nibble. Valid from T2 onward.
- `bus_in` input 8: current W-bus value.
- `bus_out` output 8: value this block drives onto W. It is 0 when not driving.
- `bus_oe` output 1: asserted when `ea` or `ev` is asserted.
- `t0`..`t5` outputs, 1 bit each: one-hot timing states.
- `lp ep lm epr li ei la ea n ev lb lo` outputs, 1 bit each, all active-high:
  - `lp`: PC increment.
  - `ep`: PC onto bus.
  - `lm`: load MAR.
  - `epr`: PROM onto bus.
  - `li`: load IR.
  - `ei`: IR address nibble onto bus.
  - `la` / `lb`: load A / B.
  - `ea`: A onto bus.
  - `n`: subtract.
  - `ev`: adder result onto bus.
  - `lo`: load output register.
- `cout` output 1: adder carry-out. For a subtract, 1 means no borrow.
- `a_reg` output 8: accumulator contents, for observation.

## Operation
- **Ring counter**
  - One-hot sequence t0→t1→t2→t3→t4→t5→t0, advancing one state per rising edge.
  - Exactly one `t*` is high at any time.
- **Halt**
  - While the halt flag is set, the ring freezes in its current state and all strobes are 0.
- **Fetch strobes** (decoded combinationally from the ring state):
  - T0: `ep`, `lm`.
  - T1: `epr`, `li`.
  - T2: `lp`.
- **Execute strobes** (T3–T5, decoded from `operate_code`):
  - LDA 4'h0: T3 `ei`, `lm`; T4 `epr`, `la`; T5 no strobes.
  - ADD 4'h1: T3 `ei`, `lm`; T4 `epr`, `lb`; T5 `ev`, `la`, with `n`=0.
  - SUB 4'h2: same strobes as ADD; `n`=1 throughout T3–T5.
  - OUT 4'hE: T3 `ea`, `lo`; T4 and T5 no strobes.
  - HLT 4'hF: at the T3 rising edge, set the halt flag. The flag stays set until `reset`.
  - Any other opcode is a NOP: no strobes in T3–T5.
- **Datapath**
  - A and B are 8-bit registers. On a rising edge, A loads `bus_in` when `la`=1, and B loads `bus_in` when `lb`=1.
- **Adder**
  - result = A + (B XOR {8{n}}) + n, computed mod 256.
  - `cout` is bit 8 of the 9-bit sum.
  - `cout` is combinational from A, B and `n`.
- **Bus drive**
  - `ea` takes priority over `ev`.
  - `ea`: `bus_out` = A.
  - `ev`: `bus_out` = result.
  - Otherwise `bus_out` = 0 and `bus_oe` = 0.
- **Bus loopback:** during ADD/SUB T5, the top-level bus mux returns `bus_out` to `bus_in`. A therefore loads the result at the end of T5.
- **Reset** (asynchronous, takes effect immediately, including mid-instruction):
  - ring = t0;
  - A = B = 0;
  - halt flag cleared;
  - all strobes then reflect T0 (`ep`=`lm`=1);
  - `cout` = 0, because A = B = 0 and `n`=0.

## Timing
- All strobes are combinational from the ring state and `operate_code`. They are stable for the whole clock period of their T-state.
- Loads take effect at the rising edge that ends the T-state.
- One instruction takes exactly 6 clocks. The next fetch starts at T0 immediately after T5.
- `operate_code` may change at the end of T1. The decoder uses it only in T3–T5.
- When `reset` deasserts, the first rising edge moves the ring to t1.
- Wrap-around:
  - 8'hFF + 8'h01 → A = 8'h00, `cout` = 1.
  - 8'h00 − 8'h01 → A = 8'hFF, `cout` = 0.
- Halt takes effect at the T3 edge, so `t4` is never asserted for HLT. From then on the ring holds and all strobes read 0.

## Test plan
- **Reset:** assert `reset` mid-T4 of an ADD → `t0`=1, `a_reg`=8'h00, `ep`=`lm`=1 within the same cycle without a clock edge. After release, t1 follows one edge later.
- **Ring:** run NOPs (opcode 4'h5) for 12 clocks → t0..t5 each asserted exactly twice, one-hot. No execute strobes.
- **LDA 8'h27 then ADD 8'h19:**
  - After the ADD T4, B = 8'h19.
  - In the ADD T5, `bus_out` = 8'h40 with `bus_oe`=1.
  - `a_reg` = 8'h40 after the ADD T5 edge; `cout`=0.
- **Overflow:** A = 8'hFF, ADD 8'h01 → `a_reg` = 8'h00, `cout` = 1.
- **SUB:** A = 8'h10, SUB 8'h11 → `n`=1 in T3–T5, `a_reg` = 8'hFF, `cout` = 0. Then SUB 8'h0F → `a_reg` = 8'hF0, `cout` = 1.
- **OUT then HLT:**
  - OUT T3 → `ea`=`lo`=1 and `bus_out` = A.
  - HLT → after the T3 edge, the ring is frozen for 20 clocks with all strobes 0.
  - Asserting `reset` restarts at t0.
